fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   F-stage of the P7 MIPS pipeline: holds PC_F, drives the instruction-memory
//   address, and registers the fetched word into the F/D pipeline register.
//   Consumes next_pc from NPC every cycle and produces PC_F / PC_D back to it.
//   Tags fetch exceptions (AdEL) and the branch-delay-slot flag for CP0 in later stages.
// PARAMETERS
//   RESET_PC    32'h0000_3000  PC_F value after reset
//   HANDLER_PC  32'h0000_4180  PC_D value loaded into the flushed F/D slot on Req
//   IM_BASE     32'h0000_3000  lowest legal fetch address
//   IM_LAST     32'h0000_6FFC  highest legal fetch address (inclusive)
// PORTS
//   clk         in   1   system clock, rising edge
//   reset       in   1   synchronous, active-high
//   next_pc     in   32  next fetch address from NPC (already 0x4180 when Req=1)
//   stall       in   1   hazard-unit freeze of PC_F and F/D
//   flush_D     in   1   clear F/D to a bubble (eret: no delay slot)
//   Req         in   1   exception/interrupt taken this cycle (from CP0)
//   branch_D    in   1   instruction now in D is a branch/jump
//   i_inst_rdata in  32  instruction word at i_inst_addr (combinational IM)
//   i_inst_addr out  32  = PC_F
//   PC_F        out  32  current fetch PC (to NPC)
//   PC_D        out  32  PC of instruction in D
//   Instr_D     out  32  instruction in D
//   BD_D        out  1   instruction in D sits in a delay slot
//   ExcCode_D   out  5   fetch exception code of D instruction (0 = none, 4 = AdEL)
//   valid_D     out  1   D holds a real (non-bubble) instruction
// BEHAVIOUR
//   - Reset (sync, highest priority): PC_F=RESET_PC; PC_D=0, Instr_D=0, BD_D=0,
//     ExcCode_D=0, valid_D=0. All outputs registered except i_inst_addr (=PC_F).
//   - PC_F update priority: reset > Req > stall > normal.
//     Req: PC_F<=next_pc regardless of stall. stall: hold. normal: PC_F<=next_pc.
//   - F/D update priority: reset > Req > stall > flush_D > normal.
//     Req: Instr_D=0, PC_D=HANDLER_PC, BD_D=0, ExcCode_D=0, valid_D=0.
//     stall: all F/D fields hold (stall overrides flush_D; flush retried next cycle).
//     flush_D: Instr_D=0, PC_D=PC_F, BD_D=0, ExcCode_D=0, valid_D=0.
//     normal: PC_D=PC_F, BD_D=branch_D, valid_D=1, Instr_D/ExcCode_D per AdEL check.
//   - AdEL check on PC_F (combinational, registered into D): fault if
//     PC_F[1:0]!=0 or PC_F<IM_BASE or PC_F>IM_LAST (unsigned 32-bit compares).
//     On fault: Instr_D=0 (nop), ExcCode_D=5'd4, PC_D=PC_F kept for EPC.
//   - BD_D sampled from branch_D of the instruction leaving D in the same edge,
//     i.e. the word entering D is a delay slot iff its predecessor is a branch.
//   - Latency: i_inst_rdata to Instr_D = 1 cycle; next_pc to PC_F = 1 cycle.
//   - Reset asserted mid-stall or with Req: reset wins, no residual state.
// CONFIGURATION
//   FETCH_ADEL_EN defined: AdEL check as above.
//   Not defined: no address check; ExcCode_D always 0, Instr_D always =
//   i_inst_rdata on normal load (misaligned/out-of-range fetch passes through).
// TESTING
//   1. reset=1 one edge, release -> PC_F=0x3000, valid_D=0; next edge with
//      next_pc=0x3004, i_inst_rdata=0x2408_0001 -> PC_D=0x3000, Instr_D=0x2408_0001.
//   2. stall=1 for 3 cycles, next_pc=0x3010 -> PC_F, PC_D, Instr_D unchanged;
//      stall=0 -> PC_F=0x3010 after one edge.
//   3. stall=1 and Req=1 together, next_pc=0x4180 -> PC_F=0x4180,
//      PC_D=0x4180, Instr_D=0, valid_D=0.
//   4. FETCH_ADEL_EN: PC_F=0x3002 then 0x7000 -> ExcCode_D=4, Instr_D=0,
//      PC_D=0x3002 / 0x7000; without macro ExcCode_D=0, Instr_D=i_inst_rdata.
//   5. branch_D=1 at load edge -> BD_D=1 with PC_D=PC_F; flush_D=1 same cycle
//      as stall=1 -> hold, flush applied on first unstalled edge (Instr_D=0, BD_D=0).

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: P7 MIPS F-stage holding PC_F, driving the instruction-memory address and loading the F/D register.
//   Optional feature macro: FETCH_ADEL_EN (enables the AdEL fetch-address check).
//   Ports:
//     clk, reset        rising-edge clock, synchronous active-high reset
//     next_pc           next fetch address from NPC
//     stall             freeze PC_F and F/D
//     flush_D           clear F/D to a bubble
//     Req               exception/interrupt taken; loads handler bubble into F/D
//     branch_D          instruction currently in D is a branch/jump
//     i_inst_rdata      instruction word at i_inst_addr
//     i_inst_addr       = PC_F
//     PC_F, PC_D        fetch PC and PC of the instruction in D
//     Instr_D           instruction in D
//     BD_D              instruction in D is a delay slot
//     ExcCode_D         fetch exception code (0 none, 4 AdEL)
//     valid_D           D holds a real instruction
module fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_BASE    = 32'h0000_3000,
    parameter logic [31:0] IM_LAST    = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] next_pc,
    input  logic        stall,
    input  logic        flush_D,
    input  logic        Req,
    input  logic        branch_D,
    input  logic [31:0] i_inst_rdata,
    output logic [31:0] i_inst_addr,
    output logic [31:0] PC_F,
    output logic [31:0] PC_D,
    output logic [31:0] Instr_D,
    output logic        BD_D,
    output logic [4:0]  ExcCode_D,
    output logic        valid_D
);
    logic adel;
`ifdef FETCH_ADEL_EN
    assign adel = (PC_F[1:0] != 2'b00) || (PC_F < IM_BASE) || (PC_F > IM_LAST);
`else
    assign adel = 1'b0;
`endif
    assign i_inst_addr = PC_F;
    always_ff @(posedge clk) begin
        if (reset)
            PC_F <= RESET_PC;
        else if (Req || !stall)
            PC_F <= next_pc;
    end
    // A faulting fetch still records PC_F in PC_D so later stages can write EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_D      <= 32'h0;
            Instr_D   <= 32'h0;
            BD_D      <= 1'b0;
            ExcCode_D <= 5'd0;
            valid_D   <= 1'b0;
        end else if (Req) begin
            PC_D      <= HANDLER_PC;
            Instr_D   <= 32'h0;
            BD_D      <= 1'b0;
            ExcCode_D <= 5'd0;
            valid_D   <= 1'b0;
        end else if (!stall) begin
            PC_D      <= PC_F;
            Instr_D   <= (flush_D || adel) ? 32'h0 : i_inst_rdata;
            BD_D      <= flush_D ? 1'b0 : branch_D;
            ExcCode_D <= (!flush_D && adel) ? 5'd4 : 5'd0;
            valid_D   <= !flush_D;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage.
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        reset, stall, flush_D, Req, branch_D;
    logic [31:0] next_pc, i_inst_rdata;
    logic [31:0] i_inst_addr, PC_F, PC_D, Instr_D;
    logic        BD_D, valid_D;
    logic [4:0]  ExcCode_D;
    int          tests = 0;
    int          failed = 0;
    typedef struct {
        string       tag;
        logic [31:0] pc_f;
        logic [31:0] pc_d;
        logic [31:0] instr;
        logic        bd;
        logic [4:0]  exc;
        logic        valid;
    } exp_t;
    exp_t exp_q[$];
    fetch_stage dut (
        .clk(clk), .reset(reset), .next_pc(next_pc), .stall(stall), .flush_D(flush_D),
        .Req(Req), .branch_D(branch_D), .i_inst_rdata(i_inst_rdata),
        .i_inst_addr(i_inst_addr), .PC_F(PC_F), .PC_D(PC_D), .Instr_D(Instr_D),
        .BD_D(BD_D), .ExcCode_D(ExcCode_D), .valid_D(valid_D)
    );
    always #5 clk = ~clk;
`ifdef FETCH_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif
    task automatic cmp(input string tag, input string fld, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s.%s: observed %h expected %h", tag, fld, got, exp);
        end
    endtask
    task automatic push(input string tag, input logic [31:0] pc_f, input logic [31:0] pc_d,
                        input logic [31:0] instr, input logic bd, input logic [4:0] exc, input logic valid);
        exp_t e;
        e.tag = tag; e.pc_f = pc_f; e.pc_d = pc_d; e.instr = instr;
        e.bd = bd; e.exc = exc; e.valid = valid;
        exp_q.push_back(e);
    endtask
    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        tests++;
        assert (exp_q.size() != 0) else begin
            failed++;
            $error("FAIL scoreboard: observed empty queue expected an entry");
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            cmp(e.tag, "PC_F", PC_F, e.pc_f);
            cmp(e.tag, "i_inst_addr", i_inst_addr, e.pc_f);
            cmp(e.tag, "PC_D", PC_D, e.pc_d);
            cmp(e.tag, "Instr_D", Instr_D, e.instr);
            cmp(e.tag, "BD_D", {31'b0, BD_D}, {31'b0, e.bd});
            cmp(e.tag, "ExcCode_D", {27'b0, ExcCode_D}, {27'b0, e.exc});
            cmp(e.tag, "valid_D", {31'b0, valid_D}, {31'b0, e.valid});
        end
    endtask
    initial begin
        reset = 1'b1; stall = 1'b0; flush_D = 1'b0; Req = 1'b0; branch_D = 1'b0;
        next_pc = 32'h0; i_inst_rdata = 32'h0;
        push("reset", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick_check();
        reset = 1'b0; next_pc = 32'h3004; i_inst_rdata = 32'h2408_0001;
        push("load", 32'h3004, 32'h3000, 32'h2408_0001, 1'b0, 5'd0, 1'b1);
        tick_check();
        stall = 1'b1; next_pc = 32'h3010; i_inst_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            push($sformatf("stall%0d", k), 32'h3004, 32'h3000, 32'h2408_0001, 1'b0, 5'd0, 1'b1);
            tick_check();
        end
        stall = 1'b0; i_inst_rdata = 32'h1111_1111;
        push("unstall", 32'h3010, 32'h3004, 32'h1111_1111, 1'b0, 5'd0, 1'b1);
        tick_check();
        stall = 1'b1; Req = 1'b1; next_pc = 32'h4180;
        push("req_stall", 32'h4180, 32'h4180, 32'h0, 1'b0, 5'd0, 1'b0);
        tick_check();
        stall = 1'b0; Req = 1'b0; next_pc = 32'h3002; i_inst_rdata = 32'h2222_2222;
        push("handler", 32'h3002, 32'h4180, 32'h2222_2222, 1'b0, 5'd0, 1'b1);
        tick_check();
        next_pc = 32'h7000; i_inst_rdata = 32'h3333_3333;
        push("misalign", 32'h7000, 32'h3002, ADEL ? 32'h0 : 32'h3333_3333, 1'b0, ADEL ? 5'd4 : 5'd0, 1'b1);
        tick_check();
        next_pc = 32'h6FFC; i_inst_rdata = 32'h4444_4444;
        push("above", 32'h6FFC, 32'h7000, ADEL ? 32'h0 : 32'h4444_4444, 1'b0, ADEL ? 5'd4 : 5'd0, 1'b1);
        tick_check();
        next_pc = 32'h3000; i_inst_rdata = 32'h5555_5555;
        push("last", 32'h3000, 32'h6FFC, 32'h5555_5555, 1'b0, 5'd0, 1'b1);
        tick_check();
        next_pc = 32'h2FFC; i_inst_rdata = 32'h6666_6666;
        push("base", 32'h2FFC, 32'h3000, 32'h6666_6666, 1'b0, 5'd0, 1'b1);
        tick_check();
        next_pc = 32'h3008; i_inst_rdata = 32'h7777_7777;
        push("below", 32'h3008, 32'h2FFC, ADEL ? 32'h0 : 32'h7777_7777, 1'b0, ADEL ? 5'd4 : 5'd0, 1'b1);
        tick_check();
        branch_D = 1'b1; next_pc = 32'h300C; i_inst_rdata = 32'h8888_8888;
        push("branch", 32'h300C, 32'h3008, 32'h8888_8888, 1'b1, 5'd0, 1'b1);
        tick_check();
        branch_D = 1'b0; stall = 1'b1; flush_D = 1'b1; next_pc = 32'h3010; i_inst_rdata = 32'h9999_9999;
        push("flush_stall", 32'h300C, 32'h3008, 32'h8888_8888, 1'b1, 5'd0, 1'b1);
        tick_check();
        stall = 1'b0;
        push("flush", 32'h3010, 32'h300C, 32'h0, 1'b0, 5'd0, 1'b0);
        tick_check();
        flush_D = 1'b0; next_pc = 32'h3014; i_inst_rdata = 32'hAAAA_AAAA;
        push("after_flush", 32'h3014, 32'h3010, 32'hAAAA_AAAA, 1'b0, 5'd0, 1'b1);
        tick_check();
        reset = 1'b1; stall = 1'b1; Req = 1'b1; next_pc = 32'h4180;
        push("reset_req", 32'h3000, 32'h0, 32'h0, 1'b0, 5'd0, 1'b0);
        tick_check();
        reset = 1'b0; stall = 1'b0; Req = 1'b0; next_pc = 32'h3004; i_inst_rdata = 32'hBBBB_BBBB;
        push("restart", 32'h3004, 32'h3000, 32'hBBBB_BBBB, 1'b0, 5'd0, 1'b1);
        tick_check();
        tests++;
        assert (exp_q.size() == 0) else begin
            failed++;
            $error("FAIL drain: observed %0d left expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
